// File: rtl/dma_pkg.sv
// Shared types and default parameters for the DMA load sequencer.
package dma_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_LEN_W          = 16;
  localparam int DEF_MAX_BURST      = 16;
  localparam int DEF_LAYER_W        = 4;
  localparam int DEF_BYTES_PER_WORD = 4;

  // Number of pointer slots that persist across layers (WGT, DIM, BIAS).
  localparam int NUM_LAYER_SEGS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    KIND_WGT  = 2'd0,
    KIND_DIM  = 2'd1,
    KIND_BIAS = 2'd2,
    KIND_IMG  = 2'd3
  } seg_kind_t;

endpackage

// File: rtl/dma_seg_cursor.sv
// Address/remaining-word cursor for the segment currently being loaded.
// Reloaded at each segment boundary; advanced by one burst per completion.
module dma_seg_cursor
  import dma_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int MAX_BURST      = DEF_MAX_BURST,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int BURST_W        = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [LEN_W-1:0]  loadLen,
  input  logic              advance,
  output logic [ADDR_W-1:0] curAddr,
  output logic [LEN_W-1:0]  remaining,
  output logic [BURST_W-1:0] burstLen
);

  logic [ADDR_W-1:0] byteStep;

  // Burst length is the smaller of the words left and the burst ceiling.
  always_comb begin
    burstLen = remaining[BURST_W-1:0];
    if (remaining >= LEN_W'(MAX_BURST)) begin
      burstLen = BURST_W'(MAX_BURST);
    end
  end

  // Address step wraps modulo 2^ADDR_W through natural truncation.
  assign byteStep = ADDR_W'(burstLen) * ADDR_W'(BYTES_PER_WORD);

  // Cursor registers: reload wins over advance; both cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      curAddr   <= '0;
      remaining <= '0;
    end else if (load) begin
      curAddr   <= loadAddr;
      remaining <= loadLen;
    end else if (advance) begin
      curAddr   <= curAddr + byteStep;
      remaining <= remaining - LEN_W'(burstLen);
    end
  end

endmodule

// File: rtl/dma_load_sequencer.sv
// Walks WGT/DIM/BIAS segments for every layer, then the IMG segment,
// issuing one burst request at a time to a DMA engine.
module dma_load_sequencer
  import dma_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int LEN_W          = DEF_LEN_W,
  parameter int MAX_BURST      = DEF_MAX_BURST,
  parameter int LAYER_W        = DEF_LAYER_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LAYER_W-1:0]          cfg_num_layers,
  input  logic [ADDR_W-1:0]           cfg_wgt_base,
  input  logic [ADDR_W-1:0]           cfg_dim_base,
  input  logic [ADDR_W-1:0]           cfg_bias_base,
  input  logic [ADDR_W-1:0]           cfg_img_base,
  input  logic [LEN_W-1:0]            cfg_wgt_words,
  input  logic [LEN_W-1:0]            cfg_dim_words,
  input  logic [LEN_W-1:0]            cfg_bias_words,
  input  logic [LEN_W-1:0]            cfg_img_words,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [ADDR_W-1:0]           req_addr,
  output logic [$clog2(MAX_BURST):0]  req_len,
  output logic [1:0]                  req_kind,
  input  logic                        xfer_done,
  output logic                        busy,
  output logic                        done,
  output logic [LAYER_W-1:0]          cur_layer
);

  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  state_t    state, stateNext;
  seg_kind_t kind, kindNext;
  logic [LAYER_W-1:0] layer, layerNext;

  // Configuration captured at start so the inputs may change mid-sequence.
  logic [LAYER_W-1:0] numLayers;
  logic [LEN_W-1:0]   wgtWords, dimWords, biasWords, imgWords;
  logic [ADDR_W-1:0]  imgBase;

  // Running pointer per per-layer segment kind (index = seg_kind_t value).
  logic [ADDR_W-1:0]  savedPtr    [NUM_LAYER_SEGS];
  logic [ADDR_W-1:0]  cfgSegBase  [NUM_LAYER_SEGS];
  logic [1:0]         kindIdx;

  logic               latchCfg;
  logic               savePtr;
  logic               cursorLoad;
  logic               cursorAdvance;
  logic [ADDR_W-1:0]  cursorLoadAddr;
  logic [LEN_W-1:0]   cursorLoadLen;
  logic [ADDR_W-1:0]  cursorAddr;
  logic [LEN_W-1:0]   cursorRemaining;
  logic [BURST_W-1:0] burstLen;

  logic [LAYER_W:0]   layerPlusOne;
  logic               moreLayers;

  assign cfgSegBase[0] = cfg_wgt_base;
  assign cfgSegBase[1] = cfg_dim_base;
  assign cfgSegBase[2] = cfg_bias_base;

  assign kindIdx      = kind;
  assign layerPlusOne = {1'b0, layer} + (LAYER_W + 1)'(1);
  assign moreLayers   = layerPlusOne < {1'b0, numLayers};

  assign req_addr  = cursorAddr;
  assign req_len   = burstLen;
  assign req_kind  = kind;
  assign cur_layer = layer;

  dma_seg_cursor #(
    .ADDR_W         (ADDR_W),
    .LEN_W          (LEN_W),
    .MAX_BURST      (MAX_BURST),
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .BURST_W        (BURST_W)
  ) u_cursor (
    .clk       (clk),
    .rst       (rst),
    .load      (cursorLoad),
    .loadAddr  (cursorLoadAddr),
    .loadLen   (cursorLoadLen),
    .advance   (cursorAdvance),
    .curAddr   (cursorAddr),
    .remaining (cursorRemaining),
    .burstLen  (burstLen)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Current segment kind and layer index.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind  <= KIND_WGT;
      layer <= '0;
    end else begin
      kind  <= kindNext;
      layer <= layerNext;
    end
  end

  // Capture the sequence configuration when a sequence begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      numLayers <= '0;
      wgtWords  <= '0;
      dimWords  <= '0;
      biasWords <= '0;
      imgWords  <= '0;
      imgBase   <= '0;
    end else if (latchCfg) begin
      numLayers <= cfg_num_layers;
      wgtWords  <= cfg_wgt_words;
      dimWords  <= cfg_dim_words;
      biasWords <= cfg_bias_words;
      imgWords  <= cfg_img_words;
      imgBase   <= cfg_img_base;
    end
  end

  // Per-kind pointers: seeded from the bases at start, and updated with the
  // cursor's end address when a segment of that kind is left, so the next
  // layer's segment continues where this one stopped.
  generate
    for (genvar gi = 0; gi < NUM_LAYER_SEGS; gi++) begin : g_saved_ptr
      always_ff @(posedge clk) begin
        if (rst) begin
          savedPtr[gi] <= '0;
        end else if (latchCfg) begin
          savedPtr[gi] <= cfgSegBase[gi];
        end else if (savePtr && (kindIdx == 2'(gi))) begin
          savedPtr[gi] <= cursorAddr;
        end
      end
    end
  endgenerate

  // Next-state, segment walking and handshake outputs.
  always_comb begin
    stateNext      = state;
    kindNext       = kind;
    layerNext      = layer;
    latchCfg       = 1'b0;
    savePtr        = 1'b0;
    cursorLoad     = 1'b0;
    cursorAdvance  = 1'b0;
    cursorLoadAddr = '0;
    cursorLoadLen  = '0;
    req_valid      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          latchCfg   = 1'b1;
          cursorLoad = 1'b1;
          layerNext  = '0;
          stateNext  = S_SELECT;
          // With no layers the only segment is IMG, so begin there directly.
          if (cfg_num_layers == '0) begin
            kindNext       = KIND_IMG;
            cursorLoadAddr = cfg_img_base;
            cursorLoadLen  = cfg_img_words;
          end else begin
            kindNext       = KIND_WGT;
            cursorLoadAddr = cfg_wgt_base;
            cursorLoadLen  = cfg_wgt_words;
          end
        end
      end

      S_SELECT: begin
        if (cursorRemaining != '0) begin
          stateNext = S_ISSUE;
        end else if (kind == KIND_IMG) begin
          stateNext = S_FINISH;
        end else begin
          // Segment exhausted: remember where it ended and load the next one.
          savePtr    = 1'b1;
          cursorLoad = 1'b1;
          case (kind)
            KIND_WGT: begin
              kindNext       = KIND_DIM;
              cursorLoadAddr = savedPtr[1];
              cursorLoadLen  = dimWords;
            end
            KIND_DIM: begin
              kindNext       = KIND_BIAS;
              cursorLoadAddr = savedPtr[2];
              cursorLoadLen  = biasWords;
            end
            default: begin
              if (moreLayers) begin
                kindNext       = KIND_WGT;
                layerNext      = layerPlusOne[LAYER_W-1:0];
                cursorLoadAddr = savedPtr[0];
                cursorLoadLen  = wgtWords;
              end else begin
                kindNext       = KIND_IMG;
                cursorLoadAddr = imgBase;
                cursorLoadLen  = imgWords;
              end
            end
          endcase
        end
      end

      S_ISSUE: begin
        req_valid = 1'b1;
        if (req_ready) begin
          stateNext = S_WAIT;
        end
      end

      S_WAIT: begin
        if (xfer_done) begin
          cursorAdvance = 1'b1;
          stateNext     = S_SELECT;
        end
      end

      S_FINISH: begin
        done      = 1'b1;
        stateNext = S_IDLE;
      end

      default: begin
        stateNext = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_load_sequencer.sv
// Scoreboard bench for dma_load_sequencer: expected requests are queued by
// the stimulus, monitors pop and compare on every accepted request or done.
module tb_dma_load_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2;
  logic [3:0]  cfg_num_layers;
  logic [31:0] cfg_wgt_base, cfg_dim_base, cfg_bias_base, cfg_img_base;
  logic [15:0] cfg_wgt_words, cfg_dim_words, cfg_bias_words, cfg_img_words;

  logic        req_valid, req_ready, xfer_done, busy, done;
  logic [31:0] req_addr;
  logic [4:0]  req_len;
  logic [1:0]  req_kind;
  logic [3:0]  cur_layer;

  logic        req_valid2, req_ready2, xfer_done2, busy2, done2;
  logic [31:0] req_addr2;
  logic [1:0]  req_len2;
  logic [1:0]  req_kind2;
  logic [3:0]  cur_layer2;

  dma_load_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_layers(cfg_num_layers),
    .cfg_wgt_base(cfg_wgt_base), .cfg_dim_base(cfg_dim_base),
    .cfg_bias_base(cfg_bias_base), .cfg_img_base(cfg_img_base),
    .cfg_wgt_words(cfg_wgt_words), .cfg_dim_words(cfg_dim_words),
    .cfg_bias_words(cfg_bias_words), .cfg_img_words(cfg_img_words),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_kind(req_kind), .xfer_done(xfer_done),
    .busy(busy), .done(done), .cur_layer(cur_layer)
  );

  dma_load_sequencer #(.MAX_BURST(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cfg_num_layers(cfg_num_layers),
    .cfg_wgt_base(cfg_wgt_base), .cfg_dim_base(cfg_dim_base),
    .cfg_bias_base(cfg_bias_base), .cfg_img_base(cfg_img_base),
    .cfg_wgt_words(cfg_wgt_words), .cfg_dim_words(cfg_dim_words),
    .cfg_bias_words(cfg_bias_words), .cfg_img_words(cfg_img_words),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
    .req_len(req_len2), .req_kind(req_kind2), .xfer_done(xfer_done2),
    .busy(busy2), .done(done2), .cur_layer(cur_layer2)
  );

  typedef struct {
    bit          isDone;
    logic [31:0] addr;
    int          len;
    int          kind;
    int          layer;   // -1: layer not checked
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int tests = 0;
  int fails = 0;
  int doneCount1 = 0;
  int doneCount2 = 0;
  int xferDelay = 0;

  function automatic exp_t mkReq(logic [31:0] a, int l, int k, int ly);
    exp_t e;
    e.isDone = 1'b0; e.addr = a; e.len = l; e.kind = k; e.layer = ly;
    return e;
  endfunction

  function automatic exp_t mkDone();
    exp_t e;
    e.isDone = 1'b1; e.addr = '0; e.len = 0; e.kind = 0; e.layer = -1;
    return e;
  endfunction

  function automatic void cmpEntry(string tag, exp_t e, bit isDn, logic [31:0] a,
                                   int l, int k, int ly);
    bit bad;
    tests++;
    bad = (e.isDone != isDn);
    if (!isDn && !bad)
      bad = (e.addr !== a) || (e.len != l) || (e.kind != k) ||
            ((e.layer >= 0) && (e.layer != ly));
    if (bad) begin
      fails++;
      $display("FAIL %s: got done=%0d addr=%h len=%0d kind=%0d layer=%0d, expected done=%0d addr=%h len=%0d kind=%0d layer=%0d",
               tag, isDn, a, l, k, ly, e.isDone, e.addr, e.len, e.kind, e.layer);
    end else if (isDn) begin
      $display("[TB] %s done ok", tag);
    end else begin
      $display("[TB] %s req ok addr=%h len=%0d kind=%0d layer=%0d", tag, a, l, k, ly);
    end
  endfunction

  function automatic void unexpected(string tag, bit isDn, logic [31:0] a, int l);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event done=%0d addr=%h len=%0d, expected nothing", tag, isDn, a, l);
  endfunction

  // Monitor for the default-configuration instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        if (q1.size() == 0) unexpected("dut1", 1'b0, req_addr, int'(req_len));
        else cmpEntry("dut1", q1.pop_front(), 1'b0, req_addr, int'(req_len),
                      int'(req_kind), int'(cur_layer));
      end
      if (done) begin
        doneCount1++;
        if (q1.size() == 0) unexpected("dut1", 1'b1, 32'h0, 0);
        else cmpEntry("dut1", q1.pop_front(), 1'b1, req_addr, 0, 0, 0);
      end
    end
  end

  // Monitor for the MAX_BURST=2 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid2 && req_ready2) begin
        if (q2.size() == 0) unexpected("dut2", 1'b0, req_addr2, int'(req_len2));
        else cmpEntry("dut2", q2.pop_front(), 1'b0, req_addr2, int'(req_len2),
                      int'(req_kind2), int'(cur_layer2));
      end
      if (done2) begin
        doneCount2++;
        if (q2.size() == 0) unexpected("dut2", 1'b1, 32'h0, 0);
        else cmpEntry("dut2", q2.pop_front(), 1'b1, req_addr2, 0, 0, 0);
      end
    end
  end

  // DMA engine model for dut: completes each accepted request after xferDelay cycles.
  initial begin
    xfer_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) begin
        @(posedge clk); #1;
        repeat (xferDelay) begin @(posedge clk); #1; end
        xfer_done = 1'b1;
        @(posedge clk); #1;
        xfer_done = 1'b0;
      end
    end
  end

  // DMA engine model for dut2: always ready, completes immediately.
  initial begin
    xfer_done2 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && req_valid2 && req_ready2) begin
        @(posedge clk); #1;
        xfer_done2 = 1'b1;
        @(posedge clk); #1;
        xfer_done2 = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] %s ok (%h)", name, act);
    end
  endtask

  task automatic setCfg(input logic [3:0] nl,
                        input logic [31:0] wb, input logic [15:0] wl,
                        input logic [31:0] db, input logic [15:0] dl,
                        input logic [31:0] bb, input logic [15:0] bl,
                        input logic [31:0] ib, input logic [15:0] il);
    cfg_num_layers = nl;
    cfg_wgt_base = wb;  cfg_wgt_words = wl;
    cfg_dim_base = db;  cfg_dim_words = dl;
    cfg_bias_base = bb; cfg_bias_words = bl;
    cfg_img_base = ib;  cfg_img_words = il;
  endtask

  task automatic pulseStart(input bit second);
    if (second) start2 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic waitDone(input bit second, input int c0, input string name);
    int n = 0;
    while (((second ? doneCount2 : doneCount1) == c0) && (n < 300)) begin
      tick();
      n++;
    end
    tests++;
    if ((second ? doneCount2 : doneCount1) == c0) begin
      fails++;
      $display("FAIL %s: got no done within 300 cycles, expected done pulse", name);
    end else begin
      $display("[TB] %s completed in %0d cycles", name, n);
    end
  endtask

  initial begin
    int c0;
    int n;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    req_ready = 1'b1; req_ready2 = 1'b1;
    setCfg(4'd0, 32'h0, 16'd0, 32'h0, 16'd0, 32'h0, 16'd0, 32'h0, 16'd0);
    repeat (3) tick();
    // Reset state
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cur_layer", 64'(cur_layer), 64'd0);
    chk("rst_req_addr", 64'(req_addr), 64'd0);
    chk("rst_req_len", 64'(req_len), 64'd0);
    chk("rst_req_kind", 64'(req_kind), 64'd0);
    rst = 1'b0;
    tick();

    // One layer, WGT split across bursts, empty DIM skipped, BIAS, no IMG
    setCfg(4'd1, 32'h1000, 16'd20, 32'h3000, 16'd0, 32'h2000, 16'd4, 32'h4000, 16'd0);
    q1.push_back(mkReq(32'h1000, 16, 0, 0));
    q1.push_back(mkReq(32'h1040, 4, 0, 0));
    q1.push_back(mkReq(32'h2000, 4, 2, 0));
    q1.push_back(mkDone());
    c0 = doneCount1;
    pulseStart(1'b0);
    chk("lat_t1_valid", 64'(req_valid), 64'd0);
    chk("lat_t1_busy", 64'(busy), 64'd1);
    tick();
    chk("lat_t2_valid", 64'(req_valid), 64'd1);
    waitDone(1'b0, c0, "seq_one_layer");
    tick();
    chk("one_layer_busy_fall", 64'(busy), 64'd0);

    // Two layers with persistent pointers and a trailing IMG segment
    xferDelay = 2;
    setCfg(4'd2, 32'h0, 16'd8, 32'h100, 16'd2, 32'h200, 16'd1, 32'h300, 16'd5);
    q1.push_back(mkReq(32'h000, 8, 0, 0));
    q1.push_back(mkReq(32'h100, 2, 1, 0));
    q1.push_back(mkReq(32'h200, 1, 2, 0));
    q1.push_back(mkReq(32'h020, 8, 0, 1));
    q1.push_back(mkReq(32'h108, 2, 1, 1));
    q1.push_back(mkReq(32'h204, 1, 2, 1));
    q1.push_back(mkReq(32'h300, 5, 3, -1));
    q1.push_back(mkDone());
    c0 = doneCount1;
    pulseStart(1'b0);
    waitDone(1'b0, c0, "seq_two_layers");
    tick();

    // Back-pressure: request held stable for 5 cycles, accepted once
    xferDelay = 0;
    req_ready = 1'b0;
    setCfg(4'd1, 32'h1000, 16'd20, 32'h3000, 16'd0, 32'h2000, 16'd4, 32'h4000, 16'd0);
    q1.push_back(mkReq(32'h1000, 16, 0, 0));
    q1.push_back(mkReq(32'h1040, 4, 0, 0));
    q1.push_back(mkReq(32'h2000, 4, 2, 0));
    q1.push_back(mkDone());
    c0 = doneCount1;
    pulseStart(1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), 64'(req_valid), 64'd1);
      chk($sformatf("stall%0d_addr", i), 64'(req_addr), 64'h1000);
      chk($sformatf("stall%0d_len", i), 64'(req_len), 64'd16);
      chk($sformatf("stall%0d_kind", i), 64'(req_kind), 64'd0);
      tick();
    end
    req_ready = 1'b1;
    waitDone(1'b0, c0, "seq_backpressure");
    tick();

    // All segments empty: done without any request
    setCfg(4'd2, 32'h10, 16'd0, 32'h20, 16'd0, 32'h30, 16'd0, 32'h40, 16'd0);
    q1.push_back(mkDone());
    c0 = doneCount1;
    pulseStart(1'b0);
    waitDone(1'b0, c0, "seq_all_empty");
    tick();
    chk("all_empty_busy_fall", 64'(busy), 64'd0);

    // Reset while waiting on a transfer; the late completion is ignored
    xferDelay = 6;
    setCfg(4'd1, 32'h400, 16'd8, 32'h500, 16'd0, 32'h600, 16'd0, 32'h700, 16'd0);
    q1.push_back(mkReq(32'h400, 8, 0, 0));
    c0 = doneCount1;
    pulseStart(1'b0);
    n = 0;
    while (q1.size() != 0 && n < 50) begin tick(); n++; end
    chk("abort_req_accepted", 64'(q1.size()), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_req_valid", 64'(req_valid), 64'd0);
    chk("abort_req_addr", 64'(req_addr), 64'd0);
    repeat (8) tick();
    chk("late_xfer_busy", 64'(busy), 64'd0);
    chk("late_xfer_no_done", 64'(doneCount1), 64'(c0));
    chk("late_xfer_req_valid", 64'(req_valid), 64'd0);
    xferDelay = 0;
    q1.push_back(mkReq(32'h400, 8, 0, 0));
    q1.push_back(mkDone());
    pulseStart(1'b0);
    waitDone(1'b0, c0, "seq_after_abort");
    tick();

    // MAX_BURST=2 instance: IMG-only load wrapping past the top of memory
    setCfg(4'd0, 32'h0, 16'd0, 32'h0, 16'd0, 32'h0, 16'd0, 32'hFFFF_FFF8, 16'd3);
    q2.push_back(mkReq(32'hFFFF_FFF8, 2, 3, 0));
    q2.push_back(mkReq(32'h0000_0000, 1, 3, 0));
    q2.push_back(mkDone());
    c0 = doneCount2;
    pulseStart(1'b1);
    waitDone(1'b1, c0, "seq_wrap");
    tick();
    chk("wrap_busy_fall", 64'(busy2), 64'd0);

    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dma_load_sequencer.md
DMA_LOAD_SEQUENCER -- requirements
Module: dma_load_sequencer

Interface
REQ-001 Parameter: ADDR_W, 32, address width in bits.
REQ-002 Parameter: LEN_W, 16, segment word-count width.
REQ-003 Parameter: MAX_BURST, 16, maximum words per request; SHALL be a power of two ≥1.
REQ-004 Parameter: LAYER_W, 4, layer-count width.
REQ-005 Parameter: BYTES_PER_WORD, 4, byte step per word.
REQ-006 Ports SHALL be, one per line, name direction width meaning:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin load sequence.
- cfg_num_layers  in  LAYER_W  layer count.
- cfg_wgt_base / cfg_dim_base / cfg_bias_base / cfg_img_base  in  ADDR_W  segment base byte addresses.
- cfg_wgt_words / cfg_dim_words / cfg_bias_words / cfg_img_words  in  LEN_W  words per layer (img: total).
- req_valid  out  1  request offered to DMA engine.
- req_ready  in  1  DMA engine accepts request.
- req_addr  out  ADDR_W  request start byte address.
- req_len  out  $clog2(MAX_BURST)+1  request word count, 1..MAX_BURST.
- req_kind  out  2  segment kind (WGT=0, DIM=1, BIAS=2, IMG=3).
- xfer_done  in  1  one-cycle completion of the outstanding request.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse, sequence complete.
- cur_layer  out  LAYER_W  layer index of current segment.

Function
REQ-007 FSM states: IDLE, SELECT, ISSUE, WAIT, FINISH.
REQ-008 IDLE: start=1 latches all cfg_* inputs, sets layer=0, kind=WGT, pointers to bases, remaining=cfg_wgt_words -> SELECT; start in any other state ignored.
REQ-009 Segment order: for layer 0..cfg_num_layers-1: WGT, DIM, BIAS; then IMG once; cfg_num_layers=0 goes straight to IMG.
REQ-010 WGT/DIM/BIAS pointers persist across layers: layer n segment starts where layer n-1 segment of the same kind ended.
REQ-011 SELECT: remaining≠0 -> ISSUE; remaining=0 with segments left -> load next segment, stay SELECT (one cycle per skipped segment); no segments left -> FINISH.
REQ-012 ISSUE: req_valid=1, req_len=min(remaining, MAX_BURST), req_addr=current pointer, req_kind, cur_layer stable; req_ready=1 -> WAIT.
REQ-013 req_* outputs SHALL not change while req_valid=1 and req_ready=0.
REQ-014 Exactly one request outstanding; xfer_done outside WAIT ignored.
REQ-015 WAIT: xfer_done=1 -> remaining -= req_len, pointer += req_len*BYTES_PER_WORD (mod 2^ADDR_W) -> SELECT.
REQ-016 FINISH: done=1 for exactly one cycle -> IDLE.
REQ-017 busy=1 in every state except IDLE.
REQ-018 Latency: start in cycle t -> req_valid=1 in cycle t+2 when the first segment is non-empty.
REQ-019 All lengths zero: done pulses; zero requests issued.
REQ-020 Address overflow wraps silently; no error output.

Reset
REQ-021 rst=1 at any clock edge, mid-sequence included: state=IDLE, req_valid=0, busy=0, done=0, cur_layer=0, req_addr=0, req_len=0, req_kind=WGT, counters cleared; rst overrides start.
REQ-022 Any xfer_done for a request issued before reset SHALL be ignored.

Structure
REQ-023 Package dma_pkg SHALL hold state_t, seg_kind_t, and default parameter constants.
REQ-024 Sub-module dma_seg_cursor SHALL hold pointer/remaining registers and the burst-length min logic; one instance, reloaded per segment.

Verification
REQ-025 Layers=1, wgt=20 @0x1000, dim=0, bias=4 @0x2000, img=0, ready tied 1 -> requests (0x1000,16,WGT),(0x1040,4,WGT),(0x2000,4,BIAS); done after third xfer_done.
REQ-026 Layers=2, wgt=8 @0x0, dim=2 @0x100, bias=1 @0x200, img=5 @0x300 -> 7 requests in order WGT/DIM/BIAS per layer, layer-1 addrs 0x20,0x108,0x204; final IMG (0x300,5); cur_layer 0,0,0,1,1,1.
REQ-027 req_ready held 0 for 5 cycles in ISSUE -> req_* stable throughout; single acceptance.
REQ-028 All lengths 0 -> done pulses, no req_valid, busy falls.
REQ-029 rst mid-WAIT then late xfer_done -> IDLE, no state change, busy=0; new start runs from bases.
REQ-030 img=3 @0xFFFF_FFF8, MAX_BURST=2 -> addrs 0xFFFF_FFF8, 0x0000_0000 (wrap), lens 2,1.
